// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, two write ports
// (ALU and load writeback) with same-cycle bypass, a hard-wired zero register
// and a pending-load scoreboard that flags reads of registers awaiting data.
module regfile_mp #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AW       = $clog2(DEPTH),
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = DEPTH - 1
) (
    input  logic                   Clk,
    input  logic                   ResetL,
    input  logic [NRD*AW-1:0]      RA,
    output logic [NRD*WIDTH-1:0]   BusR,
    output logic [NRD-1:0]         RdBusy,
    input  logic                   W0En,
    input  logic [AW-1:0]          W0Addr,
    input  logic [WIDTH-1:0]       W0Data,
    input  logic                   W1En,
    input  logic [AW-1:0]          W1Addr,
    input  logic [WIDTH-1:0]       W1Data,
    input  logic                   IssueEn,
    input  logic [AW-1:0]          IssueRd
);

    localparam logic [AW-1:0] ZeroAddr = AW'(ZERO_REG);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Write ports are qualified by reset so the bypass is dead while ResetL=0.
    logic w0_live;
    logic w1_live;
    assign w0_live = W0En & ResetL;
    assign w1_live = W1En & ResetL;

    // Register array: W1 is applied after W0 so it wins on an address collision.
    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            for (int r = 0; r < int'(DEPTH); r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            if (W0En && (W0Addr != ZeroAddr)) begin
                mem_q[W0Addr] <= W0Data;
            end
            if (W1En && (W1Addr != ZeroAddr)) begin
                mem_q[W1Addr] <= W1Data;
            end
        end
    end

    // Scoreboard next state: clear on load writeback, then set on issue so a
    // newly issued load supersedes the one returning in the same cycle.
    always_comb begin
        busy_d = busy_q;
        if (W1En) begin
            busy_d[W1Addr] = 1'b0;
        end
        if (IssueEn && (IssueRd != ZeroAddr)) begin
            busy_d[IssueRd] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Read ports. The zero-register force is folded into the storage leg so
    // that W0Data/W1Data reach BusR through one one-hot 3:1 AND-OR level.
    for (genvar i = 0; i < int'(NRD); i++) begin : g_rd
        logic [AW-1:0]    ra;
        logic             is_zero;
        logic             sel_w1;
        logic             sel_w0;
        logic             sel_st;
        logic [WIDTH-1:0] st_data;

        assign ra      = RA[i*AW +: AW];
        assign is_zero = (ra == ZeroAddr);
        assign sel_w1  = w1_live && (W1Addr == ra) && !is_zero;
        assign sel_w0  = w0_live && (W0Addr == ra) && !is_zero && !sel_w1;
        assign sel_st  = !sel_w1 && !sel_w0;
        assign st_data = is_zero ? '0 : mem_q[ra];

        assign BusR[i*WIDTH +: WIDTH] = ({WIDTH{sel_w1}} & W1Data)
                                      | ({WIDTH{sel_w0}} & W0Data)
                                      | ({WIDTH{sel_st}} & st_data);

        // A load writeback hitting this address already supplies the data.
        assign RdBusy[i] = busy_q[ra] && !is_zero && !sel_w1;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the pipelined datapath. It replaces the single-write, two-read register file. It adds a configurable word width and depth, N read ports, two write ports (ALU writeback and load writeback), same-cycle write-to-read bypass, a hard-wired zero register, and a pending-load scoreboard that flags reads of registers awaiting load data.

## Interface

Parameters:
- WIDTH, 64, data word width in bits
- DEPTH, 32, number of registers; must be a power of two, at least 2
- AW, log2(DEPTH), register address width
- NRD, 2, number of read ports, 1 to 4
- ZERO_REG, DEPTH-1, index that always reads 0 and ignores writes

Ports:
- Clk  in  1  clock; all state updates on the rising edge
- ResetL  in  1  asynchronous, active-low reset
- RA  in  NRD*AW  read addresses; port i is RA[i*AW +: AW]
- BusR  out  NRD*WIDTH  read data; port i is BusR[i*WIDTH +: WIDTH]
- RdBusy  out  NRD  port i is reading a register with a load outstanding
- W0En  in  1  ALU writeback enable
- W0Addr  in  AW  ALU writeback address
- W0Data  in  WIDTH  ALU writeback data
- W1En  in  1  load writeback enable; also clears the scoreboard bit
- W1Addr  in  AW  load writeback address
- W1Data  in  WIDTH  load writeback data
- IssueEn  in  1  a load is issued this cycle
- IssueRd  in  AW  destination register of the issued load

## Operation

Storage:
- DEPTH x WIDTH register array.
- DEPTH-bit busy vector.

Writes, on the rising edge of Clk:
- W0En=1 writes W0Data into the register at W0Addr.
- W1En=1 writes W1Data into the register at W1Addr.
- Both enabled to the same address: W1 wins.
- Any write to ZERO_REG is dropped.

Reads are combinational per port i, with this priority:
- RA_i == ZERO_REG: BusR_i = 0.
- Else W1En and W1Addr == RA_i: BusR_i = W1Data (bypass).
- Else W0En and W0Addr == RA_i: BusR_i = W0Data (bypass).
- Else BusR_i = the stored value at RA_i.

Scoreboard, on the rising edge of Clk:
- IssueEn with IssueRd != ZERO_REG sets busy[IssueRd].
- W1En clears busy[W1Addr].
- Set and clear on the same register in the same cycle: the set wins, since the new load supersedes the old one.
- W0 writes never touch the busy vector.

RdBusy:
- RdBusy_i = busy[RA_i], forced to 0 when RA_i == ZERO_REG.
- RdBusy_i is also forced to 0 when W1En=1 and W1Addr == RA_i, because the bypass already supplies the load data.
- IssueEn has no same-cycle effect on RdBusy.

Reset:
- ResetL=0 immediately clears every register and every busy bit, independent of Clk.
- While ResetL=0, writes and issues are ignored and both bypass paths are disabled.
- Consequently BusR = 0 and RdBusy = 0 on every port during reset.

Width and index rules:
- Addresses of AW bits always index in range; no out-of-range handling is needed.
- No arithmetic is performed on the data.

## Timing

- Read latency: combinational, 0 cycles. RA to BusR and RdBusy has no internal register.
- Write latency:
  - visible on BusR in the same cycle through the bypass;
  - visible from storage from the cycle after the rising edge.
- Scoreboard latency: a busy bit set by IssueEn at edge k is reflected on RdBusy from cycle k+1.
- Clear latency: a W1 writeback in cycle k suppresses RdBusy combinationally in cycle k; the busy bit reads 0 from cycle k+1.
- Reset assertion:
  - asynchronous;
  - mid-cycle assertion clears state without waiting for an edge;
  - an outstanding load's busy bit is lost, and the pipeline flushes alongside.
- Reset deassertion: the first state update is on the first rising edge with ResetL=1.
- The bypass makes write-to-read a combinational path. Place the writeback muxes so that the path from W*Data to BusR is a single 3:1 mux level.

## Test plan

- Reset and zero register: assert ResetL=0 mid-cycle -> all BusR=0 and RdBusy=0 immediately. Release, write 0xDEAD to ZERO_REG via W0 -> a read of ZERO_REG returns 0.
- Basic write and read: W0 writes 0x1234 to r5 at edge k -> BusR_0 = 0x1234 in cycle k through the bypass, and again in cycle k+1 from storage with W0En=0. Read r6 -> 0.
- Dual-write collision: W0 writes 0xAAAA and W1 writes 0xBBBB to r3 in the same cycle -> BusR = 0xBBBB in that cycle and in every later cycle.
- Scoreboard set and clear: issue a load to r7 at edge k -> RdBusy_0=1 for RA_0=7 from cycle k+1. W1 writes 0x77 to r7 in cycle m -> in cycle m RdBusy_0=0 and BusR_0=0x77; busy stays 0 after edge m.
- Simultaneous issue and writeback: IssueEn to r9 and W1 to r9 in the same cycle -> RdBusy=1 for r9 in the next cycle. Issue to ZERO_REG -> RdBusy stays 0.
- Parameter sweep: run WIDTH=32, DEPTH=16, NRD=3, ZERO_REG=0 -> three independent ports each return the data of their own address. Writes to r0 are dropped, and the r15 write plus read round-trips correctly.
